// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the clocked data memory.
//   - access size encodings carried on req_size
//   - FSM state encoding for the request/response sequencer
//   - bytes_of(): number of bytes touched by an access of a given size
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Reserved size reports 4 so the range check stays conservative; such
    // requests are flagged as errors regardless.
    function automatic logic [2:0] bytes_of(input logic [1:0] size);
        case (size)
            SZ_BYTE: bytes_of = 3'd1;
            SZ_HALF: bytes_of = 3'd2;
            default: bytes_of = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational request checker and load formatter.
// Ports:
//   i_size    access size (mem_pkg SZ_* encoding)
//   i_signed  sign-extend byte/halfword loads when 1
//   i_addr    full request byte address
//   i_raw     four bytes read from i_addr..i_addr+3, little-endian
//   o_err     reserved size, misaligned, or range overflow
//   o_nbytes  bytes touched by this access
//   o_rdata   extended load result, 0 when o_err is set
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_raw,
    output logic              o_err,
    output logic [2:0]        o_nbytes,
    output logic [31:0]       o_rdata
);

    // Range arithmetic is done one bit wider than both the address bus and
    // DEPTH so addr+bytes-1 can never wrap back into the valid range.
    localparam int LW = ((ADDR_W > 17) ? ADDR_W : 17) + 1;

    logic [LW-1:0] w_last;
    logic          w_rsvd;
    logic          w_misaligned;
    logic          w_out_of_range;
    logic [31:0]   w_ext;

    assign o_nbytes       = bytes_of(i_size);
    assign w_last         = LW'(i_addr) + LW'(o_nbytes) - LW'(1);
    assign w_out_of_range = (w_last >= LW'(DEPTH));
    assign w_rsvd         = (i_size == SZ_RSVD);
    assign w_misaligned   = ((i_size == SZ_HALF) && i_addr[0]) ||
                            ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
    assign o_err          = w_rsvd | w_misaligned | w_out_of_range;

    always_comb begin
        w_ext = 32'd0;
        case (i_size)
            SZ_BYTE: w_ext = {{24{i_signed & i_raw[7]}}, i_raw[7:0]};
            SZ_HALF: w_ext = {{16{i_signed & i_raw[15]}}, i_raw[15:0]};
            SZ_WORD: w_ext = i_raw;
            default: w_ext = 32'd0;
        endcase
    end

    assign o_rdata = o_err ? 32'd0 : w_ext;

endmodule

// File: rtl/data_ram_sync.sv
// data_ram_sync: byte-addressed data memory with a valid/ready request port
// and a fixed-latency one-cycle response pulse.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake, accepted when both are 1
//   req_we                1 = store, 0 = load
//   req_size, req_signed  access size and load extension mode
//   req_addr, req_wdata   byte address and right-aligned store data
//   rsp_valid             one-cycle response pulse
//   rsp_rdata, rsp_err    response data and error flag, qualified by rsp_valid
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1 and reset is 0. req_ready is 1 only in IDLE; request
// inputs are ignored at any other time. After acceptance the block spends
// LATENCY cycles in WAIT and one cycle in RESP with rsp_valid=1.
module data_ram_sync
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    state_e        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_pend_rdata;
    logic          r_pend_err;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;

    logic          w_accept;
    logic [AW-1:0] w_idx [4];
    logic [31:0]   w_raw;
    logic          w_err;
    logic [2:0]    w_nbytes;
    logic [31:0]   w_ext;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign w_accept  = req_valid & req_ready & ~reset;

    // Lane indices wrap inside the array; a wrapped lane only matters for
    // out-of-range requests, which never write and return 0.
    always_comb begin
        w_raw = 32'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx[k] = req_addr[AW-1:0] + AW'(k);
            w_raw[8*k +: 8] = r_mem[w_idx[k]];
        end
    end

    mem_lane_align #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_align (
        .i_size   (req_size),
        .i_signed (req_signed),
        .i_addr   (req_addr),
        .i_raw    (w_raw),
        .o_err    (w_err),
        .o_nbytes (w_nbytes),
        .o_rdata  (w_ext)
    );

    // Storage is not reset; stores land at the accepting edge so a later
    // reset cannot undo them.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_accept && req_we && !w_err && (3'(k) < w_nbytes)) begin
                r_mem[w_idx[k]] <= req_wdata[8*k +: 8];
            end
        end
    end

    // Load data is captured at acceptance into a pending register and only
    // copied to the visible response registers on entry to RESP, so
    // rsp_rdata/rsp_err hold steady between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_pend_rdata <= 32'd0;
            r_pend_err   <= 1'b0;
            r_rsp_rdata  <= 32'd0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state      <= WAIT;
                        r_cnt        <= 4'(LATENCY - 1);
                        r_pend_rdata <= req_we ? 32'd0 : w_ext;
                        r_pend_err   <= w_err;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= RESP;
                        r_rsp_rdata <= r_pend_rdata;
                        r_rsp_err   <= r_pend_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_sync.sv
module tb_data_ram_sync;
    import mem_pkg::*;

    localparam int LAT_M = 3;
    localparam int LAT_1 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // shared request fields, per-instance valid
    logic        valid_m, valid_1;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        ready_m, rv_m, err_m;
    logic [31:0] rd_m;
    logic        ready_1, rv_1, err_1;
    logic [31:0] rd_1;

    data_ram_sync #(.DEPTH(256), .LATENCY(LAT_M), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(valid_m), .req_ready(ready_m),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv_m), .rsp_rdata(rd_m), .rsp_err(err_m)
    );

    data_ram_sync #(.DEPTH(256), .LATENCY(LAT_1), .ADDR_W(32)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(valid_1), .req_ready(ready_1),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv_1), .rsp_rdata(rd_1), .rsp_err(err_1)
    );

    // instance selected by the driver tasks (0 = main, 1 = LATENCY 1)
    logic        sel;
    logic        s_ready, s_rv, s_err;
    logic [31:0] s_rd;
    assign s_ready = sel ? ready_1 : ready_m;
    assign s_rv    = sel ? rv_1    : rv_m;
    assign s_err   = sel ? err_1   : err_m;
    assign s_rd    = sel ? rd_1    : rd_m;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called #1 after a rising edge. Returns the response and the number of
    // edges after the accepting edge at which rsp_valid was first seen high
    // (that value is then sampled by the following edge, i.e. edge k+1).
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int k);
        int wcnt;
        bit got;
        wcnt = 0;
        while (!s_ready && wcnt < 50) begin
            @(posedge clk); #1;
            wcnt++;
        end
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        if (sel) valid_1 = 1'b1; else valid_m = 1'b1;
        @(posedge clk); #1;
        valid_m = 1'b0; valid_1 = 1'b0;
        k = 0; got = 1'b0;
        while (!got && k < 64) begin
            @(posedge clk); #1;
            k++;
            if (s_rv) got = 1'b1;
        end
        rdata = s_rd; err = s_err;
        if (!got) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            rdata = 32'hxxxx_xxxx;
        end else begin
            @(posedge clk); #1;
            chk("rsp_pulse_one_cycle", {31'd0, s_rv}, 32'd0);
            chk("ready_after_rsp", {31'd0, s_ready}, 32'd1);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic we, input logic [1:0] sz,
                                input logic sg, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = n; v.we = we; v.size = sz; v.sgn = sg; v.addr = a;
        v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    logic [31:0] rdata;
    logic        err;
    int          k;
    int          pulses;

    initial begin
        vecs.push_back(mk("st_w_10",      1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk("ld_w_10",      0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk("ld_b_13_s",    0, SZ_BYTE, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0));
        vecs.push_back(mk("ld_b_13_u",    0, SZ_BYTE, 0, 32'h13, 32'h0, 32'h000000DE, 0));
        vecs.push_back(mk("ld_h_10_s",    0, SZ_HALF, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0));
        vecs.push_back(mk("ld_h_12_u",    0, SZ_HALF, 0, 32'h12, 32'h0, 32'h0000DEAD, 0));
        vecs.push_back(mk("st_b_11",      1, SZ_BYTE, 0, 32'h11, 32'hFFFFFF55, 32'h0, 0));
        vecs.push_back(mk("ld_w_10_b",    0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0));
        vecs.push_back(mk("st_w_20",      1, SZ_WORD, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0));
        vecs.push_back(mk("ld_h_21_mis",  0, SZ_HALF, 1, 32'h21, 32'h0, 32'h0, 1));
        vecs.push_back(mk("st_w_22_mis",  1, SZ_WORD, 0, 32'h22, 32'h11111111, 32'h0, 1));
        vecs.push_back(mk("ld_w_20_keep", 0, SZ_WORD, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0));
        vecs.push_back(mk("ld_rsvd",      0, SZ_RSVD, 0, 32'h20, 32'h0, 32'h0, 1));
        vecs.push_back(mk("st_h_30",      1, SZ_HALF, 0, 32'h30, 32'hABCD8001, 32'h0, 0));
        vecs.push_back(mk("ld_h_30_s",    0, SZ_HALF, 1, 32'h30, 32'h0, 32'hFFFF8001, 0));
        vecs.push_back(mk("st_w_fc",      1, SZ_WORD, 0, 32'hFC, 32'hA5A50F0F, 32'h0, 0));
        vecs.push_back(mk("ld_w_fc",      0, SZ_WORD, 0, 32'hFC, 32'h0, 32'hA5A50F0F, 0));
        vecs.push_back(mk("ld_h_fe_u",    0, SZ_HALF, 0, 32'hFE, 32'h0, 32'h0000A5A5, 0));
        vecs.push_back(mk("ld_b_ff_s",    0, SZ_BYTE, 1, 32'hFF, 32'h0, 32'hFFFFFFA5, 0));
        vecs.push_back(mk("ld_w_fd_oor",  0, SZ_WORD, 0, 32'hFD, 32'h0, 32'h0, 1));
        vecs.push_back(mk("ld_b_100_oor", 0, SZ_BYTE, 0, 32'h100, 32'h0, 32'h0, 1));
        vecs.push_back(mk("st_b_00",      1, SZ_BYTE, 0, 32'h00, 32'h00000011, 32'h0, 0));
        vecs.push_back(mk("st_b_8000",    1, SZ_BYTE, 0, 32'h80000000, 32'h00000077, 32'h0, 1));
        vecs.push_back(mk("ld_b_8000",    0, SZ_BYTE, 0, 32'h80000000, 32'h0, 32'h0, 1));
        vecs.push_back(mk("ld_b_00_noal", 0, SZ_BYTE, 0, 32'h00, 32'h0, 32'h00000011, 0));

        // ---------------- reset ----------------
        sel = 1'b0; reset = 1'b1; valid_m = 1'b0; valid_1 = 1'b0;
        req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",     {31'd0, ready_m}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rv_m},    32'd0);
        chk("rst_rsp_rdata", rd_m,             32'd0);
        chk("rst_rsp_err",   {31'd0, err_m},   32'd0);
        chk("rst_ready_l1",  {31'd0, ready_1}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // ---------------- LATENCY=1 instance ----------------
        sel = 1'b1;
        do_req(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, rdata, err, k);
        chk("l1_st_lat", k, LAT_1);
        chk("l1_st_err", {31'd0, err}, 32'd0);
        chk("l1_st_rdata", rdata, 32'd0);
        do_req(0, SZ_WORD, 0, 32'h10, 32'h0, rdata, err, k);
        chk("l1_ld_lat", k, LAT_1);
        chk("l1_ld_rdata", rdata, 32'hDEADBEEF);
        chk("l1_ld_err", {31'd0, err}, 32'd0);

        // ---------------- table-driven vectors, main instance ----------------
        sel = 1'b0;
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp_rdata);
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   rdata, err, k);
            chk($sformatf("%s_lat", vecs[i].name), k, LAT_M);
            chk($sformatf("%s_rdata", vecs[i].name), rdata, exp_q.pop_front());
            chk($sformatf("%s_err", vecs[i].name), {31'd0, err}, {31'd0, vecs[i].exp_err});
        end

        // ---------------- handshake: valid held, fields change during WAIT ----------------
        req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        valid_m = 1'b1;
        @(posedge clk); #1;   // accepting edge (main instance is idle)
        pulses = 0; k = 0;
        while (pulses == 0 && k < 40) begin
            req_we = 1'b1; req_addr = 32'h10 + 32'(4 * (k % 3));
            req_wdata = 32'h00000000;
            @(posedge clk); #1;
            k++;
            if (rv_m) begin
                pulses++;
                chk("hs_rdata", rd_m, 32'hDEADBEEF & 32'hFFFF00FF | 32'h00005500);
                chk("hs_ready_in_resp", {31'd0, ready_m}, 32'd0);
                valid_m = 1'b0;
            end
        end
        chk("hs_one_pulse", pulses, 1);
        chk("hs_lat", k, LAT_M);
        @(posedge clk); #1;
        chk("hs_ready_back", {31'd0, ready_m}, 32'd1);
        chk("hs_no_second_rsp", {31'd0, rv_m}, 32'd0);
        do_req(0, SZ_WORD, 0, 32'h10, 32'h0, rdata, err, k);
        chk("hs_no_store_10", rdata, 32'hDEAD55EF);
        do_req(0, SZ_WORD, 0, 32'h14, 32'h0, rdata, err, k);
        chk("hs_no_store_14", {31'd0, err}, 32'd0);

        // ---------------- reset in WAIT after a store ----------------
        do_req(0, SZ_WORD, 0, 32'h20, 32'h0, rdata, err, k);
        chk("pre_rst_rdata", rdata, 32'hCAFEF00D);
        req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h40; req_wdata = 32'h12345678;
        valid_m = 1'b1;
        @(posedge clk); #1;   // accepted
        valid_m = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", {31'd0, rv_m},    32'd0);
        chk("mid_rst_rdata", rd_m,             32'd0);
        chk("mid_rst_err",   {31'd0, err_m},   32'd0);
        chk("mid_rst_ready", {31'd0, ready_m}, 32'd1);
        reset = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rv_m) pulses++;
        end
        chk("mid_rst_dropped", pulses, 0);
        do_req(0, SZ_WORD, 0, 32'h40, 32'h0, rdata, err, k);
        chk("mid_rst_store_kept", rdata, 32'h12345678);

        // ---------------- request presented with reset high ----------------
        do_req(1, SZ_WORD, 0, 32'h44, 32'h00000000, rdata, err, k);
        reset = 1'b1;
        req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h44; req_wdata = 32'h99999999;
        valid_m = 1'b1;
        @(posedge clk); #1;
        valid_m = 1'b0;
        reset = 1'b0;
        chk("rst_req_not_accepted", {31'd0, ready_m}, 32'd1);
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rv_m) pulses++;
        end
        chk("rst_req_no_rsp", pulses, 0);
        do_req(0, SZ_WORD, 0, 32'h44, 32'h0, rdata, err, k);
        chk("rst_req_no_write", rdata, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
